// File: rtl/matmul_core_param.sv
// matmul_core_param: N x N integer matrix multiply engine.
// Operands stream in byte-wide (A then B, both row-major), the product is
// built with one multiply-accumulate per cycle, and C streams out row-major.
// The multiplier output is registered before the add, so the accumulate of
// the last product lands one cycle after the last multiply; this extra
// stage is what sets the N^3+1 edge latency to the first result.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; C retained, out_data driven to 0
// S_LOAD    | accepting 2*N*N operand elements (A first, then B)
// S_COMPUTE | issuing N^3 products (i outer, j middle, k inner), then drain
// S_OUTPUT  | presenting C row-major over the valid/ready result port
module matmul_core_param #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             accum,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam int NN  = N * N;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int CIW = (NN > 1) ? $clog2(NN) : 1;
    localparam int LW  = $clog2(2 * NN);
    localparam int PW  = 2 * DW + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]    a_q [NN];
    logic [DW-1:0]    b_q [NN];
    logic [ACC_W-1:0] c_q [NN];

    logic [LW-1:0]    load_cnt_q;
    logic [KW-1:0]    i_q, j_q, k_q;
    logic             iss_done_q;
    logic             signed_q;
    logic             mac_v_q;
    logic             mac_last_q;
    logic [CIW-1:0]   mac_idx_q;
    logic [ACC_W-1:0] prod_q;
    logic [CIW-1:0]   out_idx_q;
    logic             done_q, done_d;

    logic             start_acc;
    logic             in_fire;
    logic             out_fire;
    logic             last_load;
    logic             last_out;
    logic             iss;
    logic             last_iss;

    logic [DW-1:0]    a_sel;
    logic [DW-1:0]    b_sel;
    logic [CIW-1:0]   c_sel_idx;
    int               a_idx;
    int               b_idx;
    int               c_idx;
    logic signed [PW-1:0]    prod_full;
    logic signed [ACC_W-1:0] prod_ext;

    assign start_acc = (state_q == S_IDLE) && start;
    assign in_fire   = (state_q == S_LOAD) && in_valid;
    assign out_fire  = (state_q == S_OUTPUT) && out_ready;
    assign last_load = (load_cnt_q == LW'(2 * NN - 1));
    assign last_out  = (out_idx_q == CIW'(NN - 1));
    assign iss       = (state_q == S_COMPUTE) && !iss_done_q;
    assign last_iss  = (i_q == KW'(N - 1)) && (j_q == KW'(N - 1)) && (k_q == KW'(N - 1));

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUTPUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

    // Operand select for the current (i, j, k) step.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        a_idx = int'(i_q) * N + int'(k_q);
        b_idx = int'(k_q) * N + int'(j_q);
        c_idx = int'(i_q) * N + int'(j_q);
        for (int e = 0; e < NN; e++) begin
            if (a_idx == e) a_sel = a_q[e];
            if (b_idx == e) b_sel = b_q[e];
        end
        c_sel_idx = CIW'(c_idx);
    end

    // Both operands get one extra bit (sign or zero) so a single signed
    // multiplier covers both modes; the true product always fits in 2*DW bits.
    assign prod_full = $signed({signed_q & a_sel[DW-1], a_sel}) *
                       $signed({signed_q & b_sel[DW-1], b_sel});
    assign prod_ext  = ACC_W'(prod_full);

    // Next-state and done-pulse decode.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_fire && last_load) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (mac_v_q && mac_last_q) state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_fire && last_out) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Load, compute and output counters plus the multiply pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            iss_done_q <= 1'b0;
            signed_q   <= 1'b0;
            mac_v_q    <= 1'b0;
            mac_last_q <= 1'b0;
            mac_idx_q  <= '0;
            prod_q     <= '0;
            out_idx_q  <= '0;
        end else begin
            mac_v_q    <= iss;
            mac_last_q <= iss && last_iss;
            mac_idx_q  <= c_sel_idx;
            prod_q     <= prod_ext;

            if (start_acc) begin
                signed_q   <= signed_mode;
                load_cnt_q <= '0;
                i_q        <= '0;
                j_q        <= '0;
                k_q        <= '0;
                iss_done_q <= 1'b0;
                out_idx_q  <= '0;
            end

            if (in_fire) load_cnt_q <= load_cnt_q + LW'(1);

            if (iss) begin
                if (k_q == KW'(N - 1)) begin
                    k_q <= '0;
                    if (j_q == KW'(N - 1)) begin
                        j_q <= '0;
                        if (i_q == KW'(N - 1)) begin
                            i_q        <= '0;
                            iss_done_q <= 1'b1;
                        end else begin
                            i_q <= i_q + KW'(1);
                        end
                    end else begin
                        j_q <= j_q + KW'(1);
                    end
                end else begin
                    k_q <= k_q + KW'(1);
                end
            end

            if (out_fire) out_idx_q <= last_out ? '0 : out_idx_q + CIW'(1);
        end
    end

    // Operand storage; contents are meaningless until loaded, so no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int e = 0; e < NN; e++) begin
                if (load_cnt_q == LW'(e))      a_q[e] <= in_data;
                if (load_cnt_q == LW'(NN + e)) b_q[e] <= in_data;
            end
        end
    end

    // Result matrix: cleared on reset or a non-accumulating start, else accumulates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NN; e++) c_q[e] <= '0;
        end else if (start_acc && !accum) begin
            for (int e = 0; e < NN; e++) c_q[e] <= '0;
        end else if (mac_v_q) begin
            for (int e = 0; e < NN; e++) begin
                if (mac_idx_q == CIW'(e)) c_q[e] <= c_q[e] + prod_q;
            end
        end
    end

    // Result mux; forced to zero outside the output phase.
    always_comb begin
        out_data = '0;
        if (state_q == S_OUTPUT) begin
            for (int e = 0; e < NN; e++) begin
                if (out_idx_q == CIW'(e)) out_data = c_q[e];
            end
        end
    end

endmodule

// File: tb/tb_matmul_core_param.sv
// Directed bench for matmul_core_param at N=2, DW=8, ACC_W=18.
module tb_matmul_core_param;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic        accum;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic        busy;
    logic        done;

    int n_chk;
    int n_err;

    matmul_core_param #(.N(2), .DW(8), .ACC_W(18)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .accum       (accum),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic start_run(input logic sm, input logic ac);
        @(negedge clk);
        start       = 1'b1;
        signed_mode = sm;
        accum       = ac;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // a and b are packed row-major, element 0 in the top byte.
    task automatic load_all(input logic [31:0] a, input logic [31:0] b, input bit gaps);
        logic [63:0] ops;
        ops = {a, b};
        for (int e = 0; e < 8; e++) begin
            if (gaps && e > 0) @(negedge clk);
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = ops[63 - 8 * e -: 8];
            chk("in_ready_load", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'hA5;
        end
    endtask

    task automatic wait_out(input bit pulse_start);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            start = (pulse_start && cnt == 2);
            if (cnt < 9) chk("busy_compute", {31'd0, busy}, 32'd1);
            if (cnt < 9) chk("in_ready_compute", {31'd0, in_ready}, 32'd0);
        end
        start = 1'b0;
        chk("latency", cnt, 32'd9);
    endtask

    // exp packs C row-major, 18 bits per element, element 0 on top.
    task automatic drain(input logic [71:0] exp, input bit stall);
        logic [17:0] ev;
        for (int e = 0; e < 4; e++) begin
            ev = exp[71 - 18 * e -: 18];
            if (stall && e == 1) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    out_ready = 1'b0;
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data", {14'd0, out_data}, {14'd0, ev});
                end
            end
            @(negedge clk);
            out_ready = 1'b1;
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk($sformatf("out_data[%0d]", e), {14'd0, out_data}, {14'd0, ev});
            chk("done_early", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("out_data_idle", {14'd0, out_data}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_single", {31'd0, done}, 32'd0);
    endtask

    localparam logic [31:0] A1 = 32'h01020304;
    localparam logic [31:0] B1 = 32'h05060708;
    localparam logic [71:0] C1 = {18'd19, 18'd22, 18'd43, 18'd50};
    localparam logic [71:0] C2 = {18'd38, 18'd44, 18'd86, 18'd100};
    localparam logic [71:0] CS = {18'd9, 18'd10, 18'h3FFF3, 18'h3FFF2};
    localparam logic [71:0] CX = {18'd130050, 18'd130050, 18'd130050, 18'd130050};

    initial begin
        n_chk       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        accum       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_data", {14'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // stray input valid and out_ready in IDLE must not start anything
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("idle_ignore_busy", {31'd0, busy}, 32'd0);

        // basic unsigned, then accumulate, then clear again
        start_run(1'b0, 1'b0);
        load_all(A1, B1, 1'b0);
        wait_out(1'b0);
        drain(C1, 1'b0);

        start_run(1'b0, 1'b1);
        load_all(A1, B1, 1'b0);
        wait_out(1'b0);
        drain(C2, 1'b0);

        start_run(1'b0, 1'b0);
        load_all(A1, B1, 1'b0);
        wait_out(1'b0);
        drain(C1, 1'b0);

        // signed operands
        start_run(1'b1, 1'b0);
        load_all(32'hFF0203FC, B1, 1'b0);
        wait_out(1'b0);
        drain(CS, 1'b0);

        // input gaps and output backpressure
        start_run(1'b0, 1'b0);
        load_all(A1, B1, 1'b1);
        wait_out(1'b0);
        drain(C1, 1'b1);

        // unsigned extremes
        start_run(1'b0, 1'b0);
        load_all(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_out(1'b0);
        drain(CX, 1'b0);

        // start pulsed mid-compute has no effect
        start_run(1'b0, 1'b0);
        load_all(A1, B1, 1'b0);
        wait_out(1'b1);
        drain(C1, 1'b0);

        // reset mid-compute clears C; accumulate run afterwards sees a clean C
        start_run(1'b0, 1'b1);
        load_all(A1, B1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_pre_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_run(1'b0, 1'b1);
        load_all(A1, B1, 1'b0);
        wait_out(1'b0);
        drain(C1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
